// File: rtl/alt_load_counter.sv
`default_nettype none
// ============================================================================
// Module      : alt_load_counter
// Description : Ping-pong address generator for the ECG sample buffers.
//               A programmable-length frame counter drives two BRAM
//               addresses into opposite halves of a 4096-entry buffer.
//               Port A addresses the half being filled and port B addresses
//               the half being drained. The halves swap at every frame wrap,
//               and clk_c pulses for one cycle after each wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module alt_load_counter #(
  parameter int CNT_W  = 11,
  parameter int ADDR_W = CNT_W + 1
) (
  input  logic [CNT_W-1:0]  load,
  input  logic              clk,
  output logic [ADDR_W-1:0] addra,
  output logic [ADDR_W-1:0] addrb,
  output logic              clk_c,
  output logic              switch,
  input  logic              rst_n
);

  localparam logic [CNT_W-1:0] c_zero = '0;
  localparam logic [CNT_W-1:0] c_one  = CNT_W'(1);

  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_len_q;
  logic             r_switch;
  logic             r_clk_c;

  logic [CNT_W-1:0] w_len;
  logic             w_at_start;
  logic             w_terminal;

  // The frame length is sampled only at a frame boundary (count==0). This
  // prevents a mid-frame change on load from shortening the frame below the
  // current count.
  always_comb begin
    w_at_start = (r_count == c_zero);
    w_len      = w_at_start ? load : r_len_q;
    w_terminal = (w_len != c_zero) && (r_count == (w_len - c_one));
  end

  // Frame counter, length latch, half selector and frame strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count  <= c_zero;
      r_len_q  <= c_zero;
      r_switch <= 1'b0;
      r_clk_c  <= 1'b0;
    end else begin
      if (w_at_start) begin
        r_len_q <= load;
      end
      if (w_len == c_zero) begin
        // A zero length stalls the counter at the start of a frame.
        r_count <= c_zero;
        r_clk_c <= 1'b0;
      end else if (w_terminal) begin
        r_count  <= c_zero;
        r_switch <= ~r_switch;
        r_clk_c  <= 1'b1;
      end else begin
        r_count <= r_count + c_one;
        r_clk_c <= 1'b0;
      end
    end
  end

  // The addresses are decoded directly from registers, so they change only
  // just after a clock edge. They always differ in the MSB alone.
  always_comb begin
    addra = {r_switch, r_count};
    addrb = {~r_switch, r_count};
  end

  assign clk_c  = r_clk_c;
  assign switch = r_switch;

endmodule
`default_nettype wire

// File: tb/tb_alt_load_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_alt_load_counter
// Description : Self-checking bench for alt_load_counter. It uses a vector
//               table with a scoreboard queue, plus hand-written sequences
//               for the asynchronous reset and the maximum frame length.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alt_load_counter;

  localparam int CNT_W  = 11;
  localparam int ADDR_W = 12;

  typedef struct {
    bit              rst_before;
    int              id;
    logic [CNT_W-1:0]  load;
    logic [ADDR_W-1:0] ea;
    logic [ADDR_W-1:0] eb;
    logic              ec;
    logic              es;
  } vec_t;

  logic              clk;
  logic              rst_n;
  logic [CNT_W-1:0]  load;
  logic [ADDR_W-1:0] addra;
  logic [ADDR_W-1:0] addrb;
  logic              clk_c;
  logic              switch;

  int n_checks;
  int n_pass;

  vec_t tbl[$];
  vec_t sb[$];

  alt_load_counter #(.CNT_W(CNT_W), .ADDR_W(ADDR_W)) dut (
    .load   (load),
    .clk    (clk),
    .addra  (addra),
    .addrb  (addrb),
    .clk_c  (clk_c),
    .switch (switch),
    .rst_n  (rst_n)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, " addra"},  int'(addra),  'h000);
    chk({tag, " addrb"},  int'(addrb),  'h800);
    chk({tag, " switch"}, int'(switch), 0);
    chk({tag, " clk_c"},  int'(clk_c),  0);
  endtask

  function automatic void push_vec(input bit rst, input int id, input int ld,
                                   input int cnt, input bit s, input bit c);
    vec_t v;
    v.rst_before = rst;
    v.id         = id;
    v.load       = CNT_W'(ld);
    v.ea         = {s, CNT_W'(cnt)};
    v.eb         = {~s, CNT_W'(cnt)};
    v.ec         = c;
    v.es         = s;
    tbl.push_back(v);
  endfunction

  // n edges of a frame of length L that starts from count 0 and half s0.
  // After edge k: count = k mod L, and half = s0 flipped once per completed
  // frame. The strobe is high right after each wrap.
  function automatic void add_run(input bit rst, input int id, input int L,
                                  input bit s0, input int n);
    for (int k = 1; k <= n; k++) begin
      push_vec(rst && (k == 1), id, L, k % L, s0 ^ bit'((k / L) & 1),
               (k % L) == 0);
    end
  endfunction

  initial begin
    vec_t v;
    vec_t e;
    n_checks = 0;
    n_pass   = 0;
    rst_n    = 1'b0;
    load     = '0;

    // Scenario 1: basic frame, load=10, 25 edges.
    add_run(1'b1, 1, 10, 1'b0, 25);
    // Scenario 2: load=10, then change to 4 at count=3. The current frame
    // still ends at edge 10, and the following frames are 4 long.
    add_run(1'b1, 2, 10, 1'b0, 3);
    for (int k = 4; k <= 10; k++) push_vec(1'b0, 2, 4, k % 10, k == 10, k == 10);
    add_run(1'b0, 2, 4, 1'b1, 12);
    // Scenario 3: load=1 toggles the half on every edge with the strobe held.
    add_run(1'b1, 3, 1, 1'b0, 8);
    // Scenario 4: load=0 stalls, then load=3 starts on the next edge.
    for (int k = 1; k <= 20; k++) push_vec(k == 1, 4, 0, 0, 1'b0, 1'b0);
    add_run(1'b0, 4, 3, 1'b0, 9);

    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      @(negedge clk);
      if (v.rst_before) begin
        rst_n = 1'b0;
        load  = v.load;
        #1;
        chk_reset_state($sformatf("reset s%0d", v.id));
        @(negedge clk);
        rst_n = 1'b1;
      end
      load = v.load;
      sb.push_back(v);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk($sformatf("s%0d v%0d addra", e.id, i),  int'(addra),  int'(e.ea));
      chk($sformatf("s%0d v%0d addrb", e.id, i),  int'(addrb),  int'(e.eb));
      chk($sformatf("s%0d v%0d clk_c", e.id, i),  int'(clk_c),  int'(e.ec));
      chk($sformatf("s%0d v%0d switch", e.id, i), int'(switch), int'(e.es));
    end

    // Asynchronous reset in the middle of a frame, with no clock edge.
    @(negedge clk);
    rst_n = 1'b0;
    load  = 11'd10;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("async pre addra", int'(addra), 'h005);
    #1;
    rst_n = 1'b0;
    #1;
    chk_reset_state("async mid-count");
    @(negedge clk);
    rst_n = 1'b1;

    // Maximum frame length of 2047.
    @(negedge clk);
    rst_n = 1'b0;
    load  = 11'd2047;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2046) @(posedge clk);
    #1;
    chk("max edge2046 addra",  int'(addra),  'h7FE);
    chk("max edge2046 switch", int'(switch), 0);
    chk("max edge2046 clk_c",  int'(clk_c),  0);
    @(posedge clk);
    #1;
    chk("max edge2047 addra",  int'(addra),  'h800);
    chk("max edge2047 addrb",  int'(addrb),  'h000);
    chk("max edge2047 switch", int'(switch), 1);
    chk("max edge2047 clk_c",  int'(clk_c),  1);
    @(posedge clk);
    #1;
    chk("max edge2048 addra",  int'(addra),  'h801);
    chk("max edge2048 clk_c",  int'(clk_c),  0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alt_load_counter.md
# alt_load_counter

Ping-pong address generator for the ECG sample buffers. A programmable-length frame counter produces two 12-bit BRAM addresses into the two halves of a 4096-entry buffer: port A addresses the half being filled, port B the half being drained. At the end of every frame the halves swap, `switch` toggles, and `clk_c` emits a one-cycle frame strobe. It sits between the sample-acquisition front end and the dual-port sample RAM.

## Interface
- `CNT_W`, default 11: frame-counter and `load` width.
- `ADDR_W`, default 12: address width. Fixed at `CNT_W+1`; the MSB selects the buffer half.
- `clk`  input  1  system clock; all state updates on the rising edge.
- `rst_n`  input  1  asynchronous active-low reset.
- `load`  input  CNT_W  frame length in samples; legal range 1..2047; 0 means "stalled".
- `addra`  output  ADDR_W  write-side address, `{switch, count}`.
- `addrb`  output  ADDR_W  read-side address, `{~switch, count}`.
- `clk_c`  output  1  frame strobe; high for one cycle after each frame wrap.
- `switch`  output  1  current half selector; toggles at every frame wrap.
- Positional port order: `load, clk, addra, addrb, clk_c, switch, rst_n`.
- One clock; reset is asynchronous and active-low.

## Operation
- Internal state:
  - `count[CNT_W-1:0]`: position within the current frame.
  - `len_q[CNT_W-1:0]`: latched frame length.
  - `switch` register and `clk_c` register.
- Effective length `len` = `load` when `count==0`, otherwise `len_q`.
- `len_q` loads from `load` on every rising edge where `count==0`. A change on `load` therefore takes effect only at a frame boundary.
- Per rising edge, when `len != 0`:
  - If `count == len-1` (terminal): `count`<=0, `switch`<=~`switch`, `clk_c`<=1.
  - Otherwise: `count`<=`count`+1, `clk_c`<=0.
- When `len == 0`: `count` holds at 0, `switch` holds, `clk_c`<=0.
- `len==1`: every edge is terminal. `switch` toggles every cycle and `clk_c` stays high continuously.
- `addra` and `addrb` are combinational from the registers, so they are glitch-free relative to `clk`. They always differ only in the MSB.
- Count arithmetic is unsigned and never exceeds `len-1`. No wrap past 2047 is possible because `len` ≤ 2047.
- When a `load` change at a frame boundary shortens the frame below the current count, the new `len` applies only from `count==0`, so the case cannot occur.

## Timing
- Reset (asynchronous assert, any time, including mid-frame):
  - `count`=0, `len_q`=0, `switch`=0, `clk_c`=0.
  - Hence `addra`=0x000 and `addrb`=0x800 immediately.
- First rising edge after `rst_n` deasserts: `count` goes 0→1 (if `load`>1) and `len_q` captures `load`.
- Frame period is exactly `len` clock cycles. `switch` and `clk_c` update on the same edge that returns `count` to 0.
- `clk_c` latency: high in the cycle immediately following the terminal edge, for exactly 1 cycle (continuous when `len`=1).
- No handshake. Outputs are valid every cycle.

## Test plan
- Reset check: assert `rst_n`=0 mid-count → `addra`=0x000, `addrb`=0x800, `switch`=0, `clk_c`=0, without waiting for a clock edge.
- Basic frame, `load`=10, 25 rising edges after reset:
  - `addra` runs 0x000..0x009, then 0x800..0x809, then 0x000..0x004.
  - `switch` toggles at edges 10 and 20.
  - `clk_c` is high for the cycles after edges 10 and 20 only.
  - Final `count`=5, `addrb`=0x805.
- Mid-frame length change: start with `load`=10, change to 4 at `count`=3 → the current frame still completes at 10, then subsequent frames are 4 cycles long.
- `load`=1: `switch` toggles on every edge, `clk_c` stays 1, and `addra` alternates 0x000/0x800.
- `load`=0 after reset: `count` stays 0, `switch`=0, `clk_c`=0 for 20 edges. Then set `load`=3 → the frame of 3 starts on the next edge.
- Maximum length, `load`=2047: `addra` reaches 0x7FE, then wraps to 0x800 with `switch`=1 after 2047 edges.
